ser_tx_stim: RTL and testbench
==============================

Name: ser_tx_stim

Overview:
- 8N1 UART transmitter with an input FIFO. It drives the SoC's ser_rx line so the serial receive path can be exercised: console input in simulation, or a host-side stimulus on the board.
- Bit timing matches the simpleuart link the testbench monitors on ser_tx: 106 clocks per bit, i.e. two half-periods of 53.
- Bytes are pushed through a valid/ready port and serialised back-to-back, LSB first.

Parameters:
- CLKS_PER_BIT, 106, clock cycles per serial bit; must be >= 2.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of two, >= 2.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is offered this cycle.
- in_ready  out  1  FIFO can accept a byte.
- in_data  in  8  byte to transmit.
- tx  out  1  serial output; connects to the DUT's ser_rx; idles high.
- busy  out  1  a frame is being shifted out.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH; excludes the byte currently in the shifter.

Behaviour:
- Reset (resetn low, asynchronous):
  - tx=1, busy=0, level=0, FIFO pointers=0.
  - State=IDLE, bit counter=0, baud counter=0.
  - in_ready=1 as soon as reset is released.
  - Reset asserted mid-frame: tx goes high without waiting for a clock edge; FIFO contents and the partial frame are discarded. No output appears after release until a new byte is pushed.
- Push rules:
  - A push occurs at a rising edge where in_valid & in_ready.
  - in_ready = (level != FIFO_DEPTH). It is derived from registered state only, so a push is refused when the FIFO is full even if a pop happens in the same cycle.
  - in_valid with in_ready=0 is ignored; no data is captured.
- FIFO storage: wr/rd pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- level arithmetic:
  - +1 on push only; -1 on pop only.
  - Unchanged on a simultaneous push and pop.
  - Never exceeds FIFO_DEPTH and never underflows.
- FSM states and transitions:
  - IDLE: if level != 0 at a rising edge, pop the head into the shift register, drive tx=0, baud counter=0, go to START, busy=1. A byte pushed into an empty FIFO at edge E is popped at edge E+1, so tx falls after E+1.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0]; each bit is held CLKS_PER_BIT cycles, then shift right. After bit 7 go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final stop cycle:
    - If level != 0, pop the next byte in that same edge and enter START. There is no idle gap between frames.
    - Otherwise go to IDLE with busy=0.
- Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles, which is 1060 at the defaults. Every tx transition falls exactly on a CLKS_PER_BIT boundary measured from the start-bit edge.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, then resets.
  - Bit index is 3 bits.
  - Counters are frozen in IDLE.
- tx is registered; there is no combinational path from in_* to tx.
- A push during IDLE and the pop in the following cycle are handled as separate edges. A push coinciding with a pop updates level correctly.

Test Plan:
- Reset values: hold resetn=0 for 5 cycles, then release -> tx=1, busy=0, level=0, in_ready=1. With in_valid=0 for 2000 cycles, tx stays 1.
- Single byte: push 0x55 at edge E ->
  - tx falls after E+1.
  - Sampling at the midpoint of each 106-cycle bit gives 0,1,0,1,0,1,0,1,0,1.
  - busy falls 1060 cycles after E+1, and the testbench UART monitor prints 'U'.
- Back-to-back frames: push 0x48 then 0x69 on consecutive edges ->
  - Second start bit begins exactly 1060 cycles after the first.
  - busy stays high for 2120 cycles; the monitor prints "Hi".
- Full FIFO: hold in_valid=1 for 20 cycles with in_data=0x00,0x01,... ->
  - Exactly 17 bytes accepted (0x00..0x10); level reaches 16 and in_ready=0.
  - in_ready returns to 1 one cycle after the first frame ends.
  - Output sequence is 0x00..0x10 in order.
- Reset mid-frame: push 0xA5, then drive resetn=0 during data bit 4 ->
  - tx goes to 1 immediately and level=0, busy=0.
  - After release, tx stays high with no extra frame.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=8, push 0x0F, 0xF0 ->
  - Frames are 88 cycles each, with tx high for 16 cycles between the last data bit and the next start bit.
  - Decoded bytes are 0x0F, 0xF0.

Source files
------------

// File: rtl/ser_tx_stim.sv
// ser_tx_stim: 8N1 UART transmitter fed from a byte FIFO. It drives the SoC's
// ser_rx line so the serial receive path can be exercised.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_resetn    asynchronous active-low reset
//   i_in_valid  byte offered on i_in_data this cycle
//   o_in_ready  FIFO can accept a byte (level != FIFO_DEPTH)
//   i_in_data   byte to transmit
//   o_tx        registered serial output, idles high
//   o_busy      a frame is being shifted out
//   o_level     FIFO occupancy, excludes the byte in the shifter
//
// Frames are LSB first: one start bit, eight data bits, STOP_BITS stop bits,
// each bit held CLKS_PER_BIT cycles. Frames are sent back-to-back when the
// FIFO has data at the final stop-bit cycle.
module ser_tx_stim #(
    parameter int unsigned CLKS_PER_BIT = 106,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [7:0]                    i_in_data,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   LEVEL_FULL = (PW + 1)'(FIFO_DEPTH);
    // Index of the final stop bit (0 for one stop bit, 1 for two).
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_level;
    logic [7:0]    r_shift;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic          r_stop_idx;
    logic          r_tx;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic          w_baud_done;
    logic          w_frame_end;
    logic [7:0]    w_head;

    // Ready comes from registered level only, so a full FIFO refuses a push
    // even when a pop happens on the same edge.
    assign o_in_ready  = (r_level != LEVEL_FULL);
    assign w_push      = i_in_valid && o_in_ready;
    assign w_nonempty  = (r_level != '0);
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_frame_end = (r_state == StStop) && w_baud_done && (r_stop_idx == STOP_LAST);
    assign w_pop       = w_nonempty && ((r_state == StIdle) || w_frame_end);
    assign w_head      = r_mem[r_rd_ptr];

    assign o_tx    = r_tx;
    assign o_busy  = r_busy;
    assign o_level = r_level;

    // Storage needs no reset: contents are discarded by clearing the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PW + 1)'(1);
                2'b01:   r_level <= r_level - (PW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StStart;
                    end
                end

                StStart: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= StData;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                StData: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= StStop;
                        end else begin
                            // Next bit is shift[1] before the shift lands.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                StStop: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_stop_idx == STOP_LAST) begin
                            if (w_pop) begin
                                // Chain straight into the next start bit.
                                r_shift <= w_head;
                                r_tx    <= 1'b0;
                                r_state <= StStart;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= StIdle;
                            end
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx_stim.sv
// Bench for ser_tx_stim: a default-parameter instance checked by a serial
// monitor against a byte scoreboard, and an 8-clock, two-stop-bit instance
// checked from a recorded tx trace.
module tb_ser_tx_stim;

    localparam int CPB  = 106;
    localparam int FLEN = 10 * CPB;
    localparam int CPB1 = 8;

    logic       clk;
    logic       resetn;

    logic       v0;
    logic [7:0] d0;
    logic       rdy0;
    logic       tx0;
    logic       busy0;
    logic [4:0] lvl0;

    logic       v1;
    logic [7:0] d1;
    logic       rdy1;
    logic       tx1;
    logic       busy1;
    logic [4:0] lvl1;

    int         n_vec;
    int         n_err;
    int         cyc;

    logic [7:0] sb_q[$];

    logic       m_act;
    int         m_cnt;
    int         m_bit;
    logic [7:0] m_sh;

    logic       lg  [0:255];
    logic       blg [0:255];

    typedef struct {
        logic [7:0] data;
        logic       exp_ready;
        logic [4:0] exp_level;
    } vec_t;

    vec_t tbl [20];

    ser_tx_stim #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16),
        .STOP_BITS    (1)
    ) u_dut0 (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_in_valid (v0),
        .o_in_ready (rdy0),
        .i_in_data  (d0),
        .o_tx       (tx0),
        .o_busy     (busy0),
        .o_level    (lvl0)
    );

    ser_tx_stim #(
        .CLKS_PER_BIT (CPB1),
        .FIFO_DEPTH   (16),
        .STOP_BITS    (2)
    ) u_dut1 (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_in_valid (v1),
        .o_in_ready (rdy1),
        .i_in_data  (d1),
        .o_tx       (tx1),
        .o_busy     (busy1),
        .o_level    (lvl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc counts rising edges; it is read only on falling edges.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic logic [7:0] decode8(input int s);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = lg[s + CPB1 * (b + 1) + CPB1 / 2];
        end
        return r;
    endfunction

    // Serial monitor on tx0: samples each bit at its midpoint and compares
    // the decoded byte against the scoreboard. Reset abandons a frame.
    initial begin
        m_act = 1'b0;
        m_cnt = 0;
        m_bit = 0;
        m_sh  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_act = 1'b0;
            end else if (!m_act) begin
                if (tx0 === 1'b0) begin
                    m_act = 1'b1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt % CPB == CPB / 2) begin
                    m_bit = m_cnt / CPB;
                    if (m_bit >= 1 && m_bit <= 8) begin
                        m_sh[m_bit-1] = tx0;
                    end else if (m_bit == 9) begin
                        check("mon stop bit", {31'b0, tx0}, 32'd1);
                        if (sb_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL mon unexpected frame: got %02h expected none", m_sh);
                        end else begin
                            check("mon byte", {24'b0, m_sh}, {24'b0, sb_q.pop_front()});
                        end
                        m_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int         e;
        int         bad;
        int         ones;
        logic [7:0] b55;
        logic       expb;

        n_vec  = 0;
        n_err  = 0;
        resetn = 1'b0;
        v0 = 1'b0;
        d0 = '0;
        v1 = 1'b0;
        d1 = '0;

        // Reset values.
        repeat (5) @(negedge clk);
        check("reset tx", {31'b0, tx0}, 32'd1);
        check("reset busy", {31'b0, busy0}, 32'd0);
        check("reset level", {27'b0, lvl0}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post-reset ready", {31'b0, rdy0}, 32'd1);
        check("post-reset tx", {31'b0, tx0}, 32'd1);
        check("post-reset dut1 tx", {31'b0, tx1}, 32'd1);
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("idle line stays high", bad, 32'd0);

        // Single byte 0x55: pushed at edge e, popped at e+1.
        b55 = 8'h55;
        sb_q.push_back(b55);
        v0 = 1'b1;
        d0 = b55;
        @(negedge clk);
        e  = cyc;
        v0 = 1'b0;
        check("single level after push", {27'b0, lvl0}, 32'd1);
        check("single tx before pop", {31'b0, tx0}, 32'd1);
        wait_cyc(e + 1);
        check("single start edge", {31'b0, tx0}, 32'd0);
        check("single busy", {31'b0, busy0}, 32'd1);
        check("single level after pop", {27'b0, lvl0}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(e + 1 + CPB * i + CPB / 2);
            if (i == 0) expb = 1'b0;
            else if (i == 9) expb = 1'b1;
            else expb = b55[i-1];
            check("single midpoint bit", {31'b0, tx0}, {31'b0, expb});
        end
        wait_cyc(e + FLEN);
        check("single busy last cycle", {31'b0, busy0}, 32'd1);
        wait_cyc(e + FLEN + 1);
        check("single busy falls", {31'b0, busy0}, 32'd0);
        check("single tx idle", {31'b0, tx0}, 32'd1);

        // Back-to-back 0x48, 0x69; second push lands on the first pop edge.
        sb_q.push_back(8'h48);
        sb_q.push_back(8'h69);
        v0 = 1'b1;
        d0 = 8'h48;
        @(negedge clk);
        e  = cyc;
        d0 = 8'h69;
        @(negedge clk);
        v0 = 1'b0;
        check("b2b level push+pop", {27'b0, lvl0}, 32'd1);
        check("b2b first start", {31'b0, tx0}, 32'd0);
        wait_cyc(e + FLEN);
        check("b2b stop before second", {31'b0, tx0}, 32'd1);
        wait_cyc(e + FLEN + 1);
        check("b2b second start", {31'b0, tx0}, 32'd0);
        check("b2b busy held", {31'b0, busy0}, 32'd1);
        check("b2b level drained", {27'b0, lvl0}, 32'd0);
        wait_cyc(e + 2 * FLEN);
        check("b2b busy end", {31'b0, busy0}, 32'd1);
        wait_cyc(e + 2 * FLEN + 1);
        check("b2b busy falls", {31'b0, busy0}, 32'd0);

        // Full FIFO: in_valid held 20 cycles; bytes 0x00..0x10 accepted.
        for (int k = 0; k < 20; k++) begin
            tbl[k].data      = 8'(k);
            tbl[k].exp_ready = (k <= 16);
            tbl[k].exp_level = (k == 0) ? 5'd1 : ((k > 16) ? 5'd16 : 5'(k));
        end
        for (int k = 0; k <= 16; k++) begin
            sb_q.push_back(8'(k));
        end
        for (int k = 0; k < 20; k++) begin
            v0 = 1'b1;
            d0 = tbl[k].data;
            check("full ready", {31'b0, rdy0}, {31'b0, tbl[k].exp_ready});
            @(negedge clk);
            if (k == 0) e = cyc;
            check("full level", {27'b0, lvl0}, {27'b0, tbl[k].exp_level});
        end
        v0 = 1'b0;
        wait_cyc(e + FLEN);
        check("full ready held low", {31'b0, rdy0}, 32'd0);
        check("full level at 16", {27'b0, lvl0}, 32'd16);
        wait_cyc(e + FLEN + 1);
        check("full ready returns", {31'b0, rdy0}, 32'd1);
        check("full level 15", {27'b0, lvl0}, 32'd15);
        wait_cyc(e + 1 + 17 * FLEN + 2);
        check("full drained busy", {31'b0, busy0}, 32'd0);
        check("full drained level", {27'b0, lvl0}, 32'd0);
        check("full all bytes seen", sb_q.size(), 32'd0);

        // Reset during data bit 4 of 0xA5 (that bit is 0).
        sb_q.push_back(8'hA5);
        v0 = 1'b1;
        d0 = 8'hA5;
        @(negedge clk);
        e  = cyc;
        v0 = 1'b0;
        wait_cyc(e + 1 + 5 * CPB + CPB / 2);
        check("midreset bit4 low", {31'b0, tx0}, 32'd0);
        resetn = 1'b0;
        sb_q.delete();
        #1;
        check("midreset tx async high", {31'b0, tx0}, 32'd1);
        check("midreset busy", {31'b0, busy0}, 32'd0);
        check("midreset level", {27'b0, lvl0}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (1200) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("midreset no frame after", bad, 32'd0);

        // Two stop bits, 8 clocks per bit: 0x0F then 0xF0.
        v1 = 1'b1;
        d1 = 8'h0F;
        @(negedge clk);
        e  = cyc;
        d1 = 8'hF0;
        @(negedge clk);
        v1 = 1'b0;
        for (int k = 1; k < 200; k++) begin
            wait_cyc(e + k);
            lg[k]  = tx1;
            blg[k] = busy1;
        end
        check("stop2 first start", {31'b0, lg[1 + CPB1 / 2]}, 32'd0);
        check("stop2 first byte", {24'b0, decode8(1)}, 32'h0F);
        check("stop2 last data bit", {31'b0, lg[8 * CPB1 + 8]}, 32'd0);
        ones = 0;
        for (int k = 9 * CPB1 + 1; k <= 11 * CPB1; k++) begin
            if (lg[k] === 1'b1) ones++;
        end
        check("stop2 high gap 16", ones, 32'd16);
        check("stop2 second start", {31'b0, lg[11 * CPB1 + 1]}, 32'd0);
        check("stop2 second byte", {24'b0, decode8(11 * CPB1 + 1)}, 32'hF0);
        check("stop2 busy end", {31'b0, blg[22 * CPB1]}, 32'd1);
        check("stop2 busy falls", {31'b0, blg[22 * CPB1 + 1]}, 32'd0);

        check("scoreboard empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
